// File: rtl/s_machine_gpio.sv
// Debounced switch inputs plus LED / edge / irq-mask registers on a single-cycle strobe bus.
// Reads answer one cycle after rd_en; writes land on the sampling edge; no backpressure, enable low freezes all state.
module s_machine_gpio #(
  parameter int NUM_SW    = 8,
  parameter int NUM_LED   = 8,
  parameter int DATA_W    = 16,
  parameter int DB_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [NUM_SW-1:0]  sw,
  output logic [NUM_LED-1:0] led,
  input  logic [1:0]         addr,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [DATA_W-1:0]  wdata,
  output logic [DATA_W-1:0]  rdata,
  output logic               rvalid,
  output logic               irq
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  localparam logic [1:0] A_LED    = 2'd0;
  localparam logic [1:0] A_STABLE = 2'd1;
  localparam logic [1:0] A_EDGE   = 2'd2;
  localparam logic [1:0] A_MASK   = 2'd3;

  logic [NUM_SW-1:0]          sync1_q, sync2_q;
  logic [NUM_SW-1:0]          stable_q, stable_d;
  logic [NUM_SW-1:0][CW-1:0]  cnt_q, cnt_d;
  logic [NUM_SW-1:0]          edge_q, edge_d;
  logic [NUM_SW-1:0]          mask_q;
  logic [NUM_SW-1:0]          rise;
  logic [NUM_LED-1:0]         led_q;
  logic [DATA_W-1:0]          rdata_q, rd_mux;
  logic                       rvalid_q, irq_q;
  logic                       wr_led, wr_edge, wr_mask;
  logic                       unused_wdata;

  // A pending change only counts while the synchronized level is both
  // different from the accepted level and not about to move again.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < NUM_SW; i++) begin
      if ((sync2_q[i] == stable_q[i]) || (sync1_q[i] != sync2_q[i])) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        cnt_d[i]    = '0;
        stable_d[i] = sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_comb begin
    wr_led  = wr_en && (addr == A_LED);
    wr_edge = wr_en && (addr == A_EDGE);
    wr_mask = wr_en && (addr == A_MASK);
    rise    = stable_d & ~stable_q;
    edge_d  = edge_q;
    if (wr_edge) begin
      edge_d = edge_d & ~wdata[NUM_SW-1:0];
    end
    // OR-ing the new rise last lets a fresh edge beat a same-cycle clear.
    edge_d = edge_d | rise;
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      A_LED:    rd_mux[NUM_LED-1:0] = led_q;
      A_STABLE: rd_mux[NUM_SW-1:0]  = stable_q;
      A_EDGE:   rd_mux[NUM_SW-1:0]  = edge_q;
      A_MASK:   rd_mux[NUM_SW-1:0]  = mask_q;
      default:  rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
      edge_q   <= '0;
      mask_q   <= '0;
      led_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      rvalid_q <= enable && rd_en;
      if (enable) begin
        sync1_q  <= sw;
        sync2_q  <= sync1_q;
        cnt_q    <= cnt_d;
        stable_q <= stable_d;
        edge_q   <= edge_d;
        irq_q    <= |(edge_q & mask_q);
        if (wr_led) begin
          led_q <= wdata[NUM_LED-1:0];
        end
        if (wr_mask) begin
          mask_q <= wdata[NUM_SW-1:0];
        end
        if (rd_en) begin
          rdata_q <= rd_mux;
        end
      end
    end
  end

  // Upper write-data bits have no register behind them.
  assign unused_wdata = ^wdata;

  assign led    = led_q;
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign irq    = irq_q;

endmodule

// File: doc/s_machine_gpio.md
S_MACHINE_GPIO -- requirements
Module: s_machine_gpio

Interface
REQ-001 Parameter NUM_SW, default 8, number of switch inputs (1..DATA_W).
REQ-002 Parameter NUM_LED, default 8, number of LED outputs (1..DATA_W).
REQ-003 Parameter DATA_W, default 16, register bus width.
REQ-004 Parameter DB_CYCLES, default 4, consecutive stable cycles required to accept a switch change (>=1).
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 enable  input  1  block active when high; all state held when low.
REQ-008 sw  input  NUM_SW  raw asynchronous switch levels.
REQ-009 led  output  NUM_LED  registered LED drive.
REQ-010 addr  input  2  register select.
REQ-011 wr_en  input  1  write strobe, one cycle per write.
REQ-012 rd_en  input  1  read strobe, one cycle per read.
REQ-013 wdata  input  DATA_W  write data.
REQ-014 rdata  output  DATA_W  registered read data.
REQ-015 rvalid  output  1  one-cycle pulse marking rdata valid.
REQ-016 irq  output  1  registered interrupt request, level.

Function
REQ-017 Each sw bit SHALL pass a 2-flop synchronizer before any other use.
REQ-018 Each bit SHALL have its own debounce counter, width clog2(DB_CYCLES+1), saturating at DB_CYCLES.
REQ-019 Counter clears whenever the synchronized bit equals the stable bit or changes from the previous cycle; otherwise increments.
REQ-020 Stable bit SHALL take the synchronized value in the cycle the counter reaches DB_CYCLES; counter then clears.
REQ-021 Latency raw sw change to stable change = 2 sync + DB_CYCLES cycles, exactly.
REQ-022 Register map: 0 LED (RW), 1 SW_STABLE (RO), 2 EDGE (rising-edge sticky, write-1-to-clear), 3 IRQ_MASK (RW, NUM_SW bits).
REQ-023 Writes SHALL take effect at the clock edge that samples wr_en; write to addr 1 ignored.
REQ-024 Write bits above NUM_LED/NUM_SW ignored; read bits above them return 0.
REQ-025 rd_en sampled high SHALL load rdata and pulse rvalid in the next cycle (latency 1); rdata holds until next read.
REQ-026 rd_en and wr_en together at the same addr: read returns pre-write value.
REQ-027 EDGE bit SHALL set in the cycle a stable bit goes 0->1; falling edges do not set it.
REQ-028 Same-cycle edge set and W1C on one EDGE bit: set wins, bit stays 1.
REQ-029 irq SHALL equal registered OR of (EDGE & IRQ_MASK), asserting one cycle after the contributing bit changes.
REQ-030 led SHALL equal LED register bits [NUM_LED-1:0] directly.
REQ-031 enable low: synchronizers, counters, registers, irq held; wr_en/rd_en ignored; rvalid 0.
REQ-032 Back-to-back reads every cycle SHALL be supported, one rvalid per rd_en.

Reset
REQ-033 reset high SHALL asynchronously clear synchronizers, counters, stable bits, LED, EDGE, IRQ_MASK, rdata, rvalid, irq to 0.
REQ-034 Reset mid-debounce discards the pending change; reset mid-read suppresses that rvalid.
REQ-035 After reset release, a sw held high SHALL register as a rising edge after 2+DB_CYCLES enabled cycles.

Verification
REQ-036 Write LED=0x00A5 at addr 0 -> led=0xA5 next cycle; read addr 0 -> rvalid one cycle later, rdata=0x00A5.
REQ-037 sw[0] 0->1 held, DB_CYCLES=4 -> SW_STABLE bit0=1 exactly 6 cycles later, EDGE bit0=1 same cycle.
REQ-038 sw[1] glitch high for 3 cycles (DB_CYCLES=4) -> SW_STABLE, EDGE unchanged.
REQ-039 IRQ_MASK=0x01, edge on sw[0] -> irq=1 one cycle after EDGE set; write EDGE=0x01 -> irq=0 cycle after.
REQ-040 enable low for 10 cycles with sw toggled and wr_en pulsed -> no state change, rvalid 0; resumes on enable high.
REQ-041 Assert reset during pending debounce and with LED=0xFF -> all outputs 0 immediately, no EDGE set.
